// File: rtl/monitor_pkg.sv
// Shared types and constants for the riscv-tests completion monitor.
package monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Conventional riscv-tests tohost location.
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h8000_1000;

  // riscv-tests write (test_num << 1) | 1; a value of exactly 1 means pass.
  localparam int unsigned TOHOST_PASS = 1;

endpackage

// File: rtl/tohost_snoop.sv
// Per-hart combinational detector for a completing store to tohost.
module tohost_snoop
  import monitor_pkg::*;
#(
  parameter int unsigned           XLEN        = 32,
  parameter logic [XLEN-1:0]       TOHOST_ADDR = XLEN'(DEFAULT_TOHOST_ADDR)
) (
  input  logic                st_valid,
  input  logic [XLEN-1:0]     st_addr,
  input  logic [XLEN-1:0]     st_data,
  input  logic [XLEN/8-1:0]   st_be,
  input  logic                hart_done,
  output logic                hit,
  output logic [XLEN-2:0]     code
);

  // Full-word store of an odd value to tohost by a hart not yet finished.
  always_comb begin
    hit  = st_valid && (st_addr == TOHOST_ADDR) && (&st_be) &&
           (st_data[0] == TOHOST_PASS[0]) && !hart_done;
    code = st_data[XLEN-1:1];
  end

endmodule

// File: rtl/isa_test_monitor.sv
// Completion monitor: snoops per-hart tohost stores, reports pass/fail/timeout.
module isa_test_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned     N_HARTS        = 1,
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
  parameter int unsigned     TIMEOUT_CYCLES = 100000,
  parameter int unsigned     CNT_W          = 32,
  parameter bit              STOP_ON_FAIL   = 1'b1,
  localparam int unsigned    HART_W         = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_HARTS-1:0]          st_valid,
  input  logic [N_HARTS*XLEN-1:0]     st_addr,
  input  logic [N_HARTS*XLEN-1:0]     st_data,
  input  logic [N_HARTS*(XLEN/8)-1:0] st_be,
  output logic                        running,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [HART_W-1:0]           fail_hart,
  output logic [XLEN-2:0]             fail_code,
  output logic [N_HARTS-1:0]          hart_done,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int unsigned    BW      = XLEN / 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [N_HARTS-1:0]  hart_done_q, hart_done_d;
  logic                fail_any_q, fail_any_d;
  logic [HART_W-1:0]   fail_hart_q, fail_hart_d;
  logic [XLEN-2:0]     fail_code_q, fail_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                pass_q, pass_d;

  logic [N_HARTS-1:0]  hit;
  logic [XLEN-2:0]     code [N_HARTS];

  logic                nf;
  logic [HART_W-1:0]   nf_idx;
  logic [XLEN-2:0]     nf_code;

  for (genvar h = 0; h < N_HARTS; h++) begin : g_snoop
    tohost_snoop #(
      .XLEN        (XLEN),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_snoop (
      .st_valid  (st_valid[h]),
      .st_addr   (st_addr[h*XLEN +: XLEN]),
      .st_data   (st_data[h*XLEN +: XLEN]),
      .st_be     (st_be[h*BW +: BW]),
      .hart_done (hart_done_q[h]),
      .hit       (hit[h]),
      .code      (code[h])
    );
  end

  // Lowest-index hart failing this cycle (scan high to low so the lowest wins).
  always_comb begin
    nf      = 1'b0;
    nf_idx  = '0;
    nf_code = '0;
    for (int unsigned i = 0; i < N_HARTS; i++) begin
      if (hit[N_HARTS-1-i] && (code[N_HARTS-1-i] != '0)) begin
        nf      = 1'b1;
        nf_idx  = HART_W'(N_HARTS - 1 - i);
        nf_code = code[N_HARTS-1-i];
      end
    end
  end

  // Next-state, counter, arbitration and result computation.
  always_comb begin
    state_d     = state_q;
    hart_done_d = hart_done_q;
    fail_any_d  = fail_any_q;
    fail_hart_d = fail_hart_q;
    fail_code_d = fail_code_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          hart_done_d = '0;
          fail_any_d  = 1'b0;
          fail_hart_d = '0;
          fail_code_d = '0;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
        end
      end
      RUN: begin
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        hart_done_d = hart_done_q | hit;
        // Earlier failures keep priority unless a lower-index hart fails now.
        if (nf && (!fail_any_q || (nf_idx < fail_hart_q))) begin
          fail_hart_d = nf_idx;
          fail_code_d = nf_code;
        end
        fail_any_d = fail_any_q | nf;
        if ((&hart_done_d) || (STOP_ON_FAIL && fail_any_d)) begin
          state_d = DONE;
          pass_d  = !fail_any_d;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hart_done_q <= '0;
      fail_any_q  <= 1'b0;
      fail_hart_q <= '0;
      fail_code_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hart_done_q <= hart_done_d;
      fail_any_q  <= fail_any_d;
      fail_hart_q <= fail_hart_d;
      fail_code_q <= fail_code_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_hart   = fail_hart_q;
  assign fail_code   = fail_code_q;
  assign hart_done   = hart_done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_isa_test_monitor.sv
// Directed bench: one single-hart monitor and two four-hart monitors.
module tb_isa_test_monitor;

  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  int checks = 0;
  int errors = 0;

  // single-hart DUT, TIMEOUT_CYCLES = 50
  logic        s1_valid = 1'b0;
  logic [31:0] s1_addr  = '0;
  logic [31:0] s1_data  = '0;
  logic [3:0]  s1_be    = '0;
  logic        r1_running, r1_done, r1_pass, r1_timeout;
  logic [0:0]  r1_fail_hart;
  logic [30:0] r1_fail_code;
  logic [0:0]  r1_hart_done;
  logic [31:0] r1_cnt;

  // four-hart bus shared by the stop-on-fail (a) and wait-all (b) DUTs
  logic [3:0]   s4_valid = '0;
  logic [127:0] s4_addr  = '0;
  logic [127:0] s4_data  = '0;
  logic [15:0]  s4_be    = '0;
  logic        ra_running, ra_done, ra_pass, ra_timeout;
  logic [1:0]  ra_fail_hart;
  logic [30:0] ra_fail_code;
  logic [3:0]  ra_hart_done;
  logic [31:0] ra_cnt;
  logic        rb_running, rb_done, rb_pass, rb_timeout;
  logic [1:0]  rb_fail_hart;
  logic [30:0] rb_fail_code;
  logic [3:0]  rb_hart_done;
  logic [31:0] rb_cnt;

  always #5 clk = ~clk;

  isa_test_monitor #(.N_HARTS(1), .TIMEOUT_CYCLES(50), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .st_valid(s1_valid), .st_addr(s1_addr), .st_data(s1_data), .st_be(s1_be),
    .running(r1_running), .done(r1_done), .pass(r1_pass), .timeout(r1_timeout),
    .fail_hart(r1_fail_hart), .fail_code(r1_fail_code),
    .hart_done(r1_hart_done), .cycle_count(r1_cnt));

  isa_test_monitor #(.N_HARTS(4), .TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(1'b1)) ua (
    .clk(clk), .rst(rst), .start(start),
    .st_valid(s4_valid), .st_addr(s4_addr), .st_data(s4_data), .st_be(s4_be),
    .running(ra_running), .done(ra_done), .pass(ra_pass), .timeout(ra_timeout),
    .fail_hart(ra_fail_hart), .fail_code(ra_fail_code),
    .hart_done(ra_hart_done), .cycle_count(ra_cnt));

  isa_test_monitor #(.N_HARTS(4), .TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(1'b0)) ub (
    .clk(clk), .rst(rst), .start(start),
    .st_valid(s4_valid), .st_addr(s4_addr), .st_data(s4_data), .st_be(s4_be),
    .running(rb_running), .done(rb_done), .pass(rb_pass), .timeout(rb_timeout),
    .fail_hart(rb_fail_hart), .fail_code(rb_fail_code),
    .hart_done(rb_hart_done), .cycle_count(rb_cnt));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int unsigned delay;
    logic        exp_done;
    logic        exp_pass;
    logic [30:0] exp_code;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store4(input int unsigned h, input logic [31:0] d);
    s4_valid[h]        = 1'b1;
    s4_addr[h*32 +: 32] = TOHOST;
    s4_data[h*32 +: 32] = d;
    s4_be[h*4 +: 4]     = 4'hF;
  endtask

  task automatic clear4();
    s4_valid = '0;
    s4_addr  = '0;
    s4_data  = '0;
    s4_be    = '0;
  endtask

  initial begin
    vecs[0] = '{TOHOST,           32'h0000_0001, 4'hF, 20, 1'b1, 1'b1, 31'd0};
    vecs[1] = '{TOHOST,           32'h0000_0007, 4'hF,  5, 1'b1, 1'b0, 31'd3};
    vecs[2] = '{TOHOST,           32'h0000_0001, 4'h3,  8, 1'b0, 1'b0, 31'd0};
    vecs[3] = '{TOHOST,           32'h0000_0002, 4'hF,  3, 1'b0, 1'b0, 31'd0};
    vecs[4] = '{32'h8000_1004,    32'h0000_0001, 4'hF,  4, 1'b0, 1'b0, 31'd0};
    vecs[5] = '{TOHOST,           32'hFFFF_FFFF, 4'hF,  0, 1'b1, 1'b0, 31'h7FFF_FFFF};
    vecs[6] = '{TOHOST,           32'h0000_0003, 4'hF, 10, 1'b1, 1'b0, 31'd1};

    // reset state
    #1;
    check("rst_running", r1_running, 0);
    check("rst_done", r1_done, 0);
    check("rst_pass", r1_pass, 0);
    check("rst_cnt", r1_cnt, 0);
    check("rst_b_hart_done", rb_hart_done, 0);
    #3;
    rst = 1'b0;

    // single-store vectors on the single-hart DUT
    for (int i = 0; i < 7; i++) begin
      do_reset();
      do_start();
      repeat (vecs[i].delay) tick();
      s1_valid = 1'b1;
      s1_addr  = vecs[i].addr;
      s1_data  = vecs[i].data;
      s1_be    = vecs[i].be;
      tick();
      s1_valid = 1'b0;
      s1_addr  = '0;
      s1_data  = '0;
      s1_be    = '0;
      check($sformatf("v%0d_done", i), r1_done, vecs[i].exp_done);
      check($sformatf("v%0d_running", i), r1_running, !vecs[i].exp_done);
      check($sformatf("v%0d_pass", i), r1_pass, vecs[i].exp_pass);
      check($sformatf("v%0d_code", i), r1_fail_code, vecs[i].exp_code);
      check($sformatf("v%0d_hart_done", i), r1_hart_done, vecs[i].exp_done);
      check($sformatf("v%0d_timeout", i), r1_timeout, 0);
      check($sformatf("v%0d_cnt", i), r1_cnt, vecs[i].delay + 1);
    end

    // failure result is sticky against a later passing store
    do_reset();
    do_start();
    s1_valid = 1'b1; s1_addr = TOHOST; s1_data = 32'h7; s1_be = 4'hF;
    tick();
    s1_valid = 1'b0;
    repeat (3) tick();
    s1_valid = 1'b1; s1_data = 32'h1;
    tick();
    s1_valid = 1'b0;
    check("sticky_done", r1_done, 1);
    check("sticky_pass", r1_pass, 0);
    check("sticky_code", r1_fail_code, 3);
    check("sticky_hart", r1_fail_hart, 0);
    check("sticky_cnt", r1_cnt, 1);

    // start during RUN is ignored
    do_reset();
    do_start();
    repeat (5) tick();
    do_start();
    check("start_in_run_cnt", r1_cnt, 6);
    check("start_in_run_running", r1_running, 1);

    // timeout after exactly 50 RUN cycles (continuing the run above)
    repeat (43) tick();
    check("to_pre_cnt", r1_cnt, 49);
    check("to_pre_done", r1_done, 0);
    tick();
    check("to_done", r1_done, 1);
    check("to_timeout", r1_timeout, 1);
    check("to_pass", r1_pass, 0);
    check("to_hart_done", r1_hart_done, 0);
    check("to_cnt", r1_cnt, 50);
    check("to_running", r1_running, 0);

    // re-arm from DONE clears results
    do_start();
    check("rearm_running", r1_running, 1);
    check("rearm_timeout", r1_timeout, 0);
    check("rearm_cnt", r1_cnt, 0);

    // asynchronous reset mid-RUN
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_running", r1_running, 0);
    check("arst_done", r1_done, 0);
    check("arst_cnt", r1_cnt, 0);
    rst = 1'b0;
    #1;
    do_start();
    check("arst_restart_cnt", r1_cnt, 0);

    // qualifying store on the last allowed cycle beats timeout
    repeat (49) tick();
    s1_valid = 1'b1; s1_addr = TOHOST; s1_data = 32'h1; s1_be = 4'hF;
    tick();
    s1_valid = 1'b0;
    check("edge_done", r1_done, 1);
    check("edge_pass", r1_pass, 1);
    check("edge_timeout", r1_timeout, 0);
    check("edge_cnt", r1_cnt, 50);

    // four harts: harts 3 and 1 fail together
    do_reset();
    do_start();
    repeat (2) tick();
    store4(3, 32'h9);
    store4(1, 32'h9);
    tick();
    clear4();
    check("a_done", ra_done, 1);
    check("a_fail_hart", ra_fail_hart, 1);
    check("a_fail_code", ra_fail_code, 4);
    check("a_pass", ra_pass, 0);
    check("a_hart_done", ra_hart_done, 4'b1010);
    check("a_cnt", ra_cnt, 3);
    check("b_not_done", rb_done, 0);
    check("b_running", rb_running, 1);
    check("b_hart_done1", rb_hart_done, 4'b1010);

    // hart1 repeat is ignored, hart0 fails with a lower index
    tick();
    store4(1, 32'h1);
    store4(0, 32'h5);
    tick();
    clear4();
    check("b_hart_done2", rb_hart_done, 4'b1011);
    check("b_still_running", rb_done, 0);

    tick();
    store4(2, 32'h1);
    tick();
    clear4();
    check("b_done", rb_done, 1);
    check("b_pass", rb_pass, 0);
    check("b_fail_hart", rb_fail_hart, 0);
    check("b_fail_code", rb_fail_code, 2);
    check("b_hart_done3", rb_hart_done, 4'b1111);
    check("b_timeout", rb_timeout, 0);
    check("b_cnt", rb_cnt, 7);
    check("a_held_hart", ra_fail_hart, 1);
    check("a_held_cnt", ra_cnt, 3);

    // four harts all pass together after re-arm
    do_start();
    tick();
    for (int unsigned h = 0; h < 4; h++) store4(h, 32'h1);
    tick();
    clear4();
    check("a_all_pass", ra_pass, 1);
    check("a_all_done", ra_done, 1);
    check("b_all_pass", rb_pass, 1);
    check("b_all_code", rb_fail_code, 0);
    check("b_all_hart_done", rb_hart_done, 4'b1111);
    check("b_all_cnt", rb_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
